// File: rtl/baud_tick_generator.sv
// Fractional-divisor baud tick source: oversampled RX tick and TX bit tick, runtime-reloadable divisor.
// Optional BAUD_TX_LOCK_EN derives tx_tick from every SAMPLE_RATE-th rx_tick instead of a separate accumulator.
module baud_tick_generator #(
  parameter int unsigned CLK_HZ      = 25_000_000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned SAMPLE_RATE = 16,
  parameter int unsigned FRAC_BITS   = 4,
  parameter int unsigned DIV_W       = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_rx,
  input  logic                         start_tx,
  input  logic [DIV_W+FRAC_BITS-1:0]   div_in,
  input  logic                         div_load,
  output logic                         rx_tick,
  output logic                         tx_tick,
  output logic [DIV_W+FRAC_BITS-1:0]   div_cur,
  output logic                         div_err
);

  localparam int unsigned DW  = DIV_W + FRAC_BITS;
  localparam int unsigned ONE = 2 ** FRAC_BITS;
  localparam int unsigned SW  = $clog2(SAMPLE_RATE);
  localparam logic [63:0] DEFAULT_FULL =
    (64'(CLK_HZ) * 64'(ONE)) / (64'(BAUD_RATE) * 64'(SAMPLE_RATE));
  localparam logic [DW-1:0] DEFAULT_DIV = DEFAULT_FULL[DW-1:0];
  localparam logic [DW:0]   RX_ONE      = (DW+1)'(ONE);
  localparam logic [DW-1:0] MIN_DIV     = DW'(2 * ONE);

  logic [DW-1:0] div_d, div_q;
  logic [DW:0]   rx_acc_d, rx_acc_q, rx_sum, rx_div;
  logic          rx_tick_d, rx_tick_q;
  logic          tx_tick_d, tx_tick_q;
  logic          div_err_d, div_err_q;
  logic          load_ok;

`ifdef BAUD_TX_LOCK_EN
  logic [SW-1:0] tx_cnt_d, tx_cnt_q;
`else
  localparam int unsigned TW     = DW + SW;
  localparam logic [TW:0] TX_ONE = (TW+1)'(ONE);
  logic [TW:0] tx_acc_d, tx_acc_q, tx_sum, tx_div;
`endif

  always_comb begin
    load_ok   = div_load && (div_in >= MIN_DIV);
    div_err_d = div_load && !load_ok;
    div_d     = div_q;

    // Extra accumulator MSB holds acc+ONE, which can exceed the DW-bit divisor.
    rx_div = {1'b0, div_q};
    rx_sum = rx_acc_q + RX_ONE;
    if (rx_sum >= rx_div) begin
      rx_acc_d  = rx_sum - rx_div;
      rx_tick_d = 1'b1;
    end else begin
      rx_acc_d  = rx_sum;
      rx_tick_d = 1'b0;
    end
    if (start_rx) begin
      rx_acc_d  = {1'b0, div_q >> 1};
      rx_tick_d = 1'b0;
    end

`ifdef BAUD_TX_LOCK_EN
    tx_cnt_d  = tx_cnt_q;
    tx_tick_d = 1'b0;
    if (rx_tick_d) begin
      if (tx_cnt_q == SW'(SAMPLE_RATE - 1)) begin
        tx_cnt_d  = '0;
        tx_tick_d = 1'b1;
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
    if (start_tx) begin
      tx_cnt_d  = '0;
      tx_tick_d = 1'b0;
    end
`else
    tx_div = (TW+1)'(div_q) * (TW+1)'(SAMPLE_RATE);
    tx_sum = tx_acc_q + TX_ONE;
    if (tx_sum >= tx_div) begin
      tx_acc_d  = tx_sum - tx_div;
      tx_tick_d = 1'b1;
    end else begin
      tx_acc_d  = tx_sum;
      tx_tick_d = 1'b0;
    end
    if (start_tx) begin
      tx_acc_d  = '0;
      tx_tick_d = 1'b0;
    end
`endif

    // A valid reload overrides any restart; start_rx only chooses the RX phase.
    if (load_ok) begin
      div_d     = div_in;
      rx_acc_d  = start_rx ? {1'b0, div_in >> 1} : '0;
      rx_tick_d = 1'b0;
      tx_tick_d = 1'b0;
`ifdef BAUD_TX_LOCK_EN
      tx_cnt_d  = '0;
`else
      tx_acc_d  = '0;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= DEFAULT_DIV;
      rx_acc_q  <= '0;
      rx_tick_q <= 1'b0;
      tx_tick_q <= 1'b0;
      div_err_q <= 1'b0;
`ifdef BAUD_TX_LOCK_EN
      tx_cnt_q  <= '0;
`else
      tx_acc_q  <= '0;
`endif
    end else begin
      div_q     <= div_d;
      rx_acc_q  <= rx_acc_d;
      rx_tick_q <= rx_tick_d;
      tx_tick_q <= tx_tick_d;
      div_err_q <= div_err_d;
`ifdef BAUD_TX_LOCK_EN
      tx_cnt_q  <= tx_cnt_d;
`else
      tx_acc_q  <= tx_acc_d;
`endif
    end
  end

  assign rx_tick = rx_tick_q;
  assign tx_tick = tx_tick_q;
  assign div_cur = div_q;
  assign div_err = div_err_q;

endmodule
